// File: rtl/l2_tag_mon_pkg.sv
// Shared constants and types for the L2 tag-bank request/response latency monitor.
package l2_tag_mon_pkg;

  localparam int unsigned    NUM_REQ_CH_DEF     = 4;
  localparam logic [3:0]     MANDATORY_MASK_DEF = 4'b0011;
  localparam int unsigned    MAX_LAT_DEF        = 50;
  localparam int unsigned    OUTSTANDING_DEF    = 4;
  localparam int unsigned    LAT_W_DEF          = 8;
  localparam int unsigned    CNT_W_DEF          = 16;
  localparam int unsigned    NUM_ERR            = 4;

  typedef enum logic [1:0] {
    ERR_PROTOCOL,
    ERR_TIMEOUT,
    ERR_OVERFLOW,
    ERR_UNEXPECTED
  } err_e;

  typedef struct packed {
    logic                 valid;
    logic                 flagged;
    logic [LAT_W_DEF-1:0] age;
  } age_entry_t;

  function automatic logic [LAT_W_DEF-1:0] age_inc(logic [LAT_W_DEF-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/l2_tag_mon_age_fifo.sv
// Circular FIFO of in-flight request ages; every valid entry ages by one per cycle (saturating).
module l2_tag_mon_age_fifo
  import l2_tag_mon_pkg::*;
#(
  parameter int unsigned DEPTH = OUTSTANDING_DEF,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             mark_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] count_o,
  output age_entry_t       head_o,
  output age_entry_t       next_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  age_entry_t       mem_q [DEPTH];
  age_entry_t       mem_d [DEPTH];
  logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d, nxt_ptr;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == OCC_W'(DEPTH));
    count_o = cnt_q;
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    nxt_ptr = ptr_inc(rd_q);
    head_o  = mem_q[rd_q];
    next_o  = (cnt_q > OCC_W'(1)) ? mem_q[nxt_ptr] : '0;
    rd_d    = pop_ok ? nxt_ptr : rd_q;
    wr_d    = push_ok ? ptr_inc(wr_q) : wr_q;
    cnt_d   = cnt_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (mem_q[i].valid) mem_d[i].age = age_inc(mem_q[i].age);
    end
    if (pop_ok) mem_d[rd_q] = '0;
    // A new entry is born at age 0 and aged by this same edge.
    if (push_ok) mem_d[wr_q] = '{valid: 1'b1, flagged: 1'b0, age: LAT_W_DEF'(1)};
    if (mark_i && mem_d[rd_d].valid) mem_d[rd_d].flagged = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_tag_req_latency_monitor.sv
// Protocol and latency monitor for the L2 tag bank flex channels; drives nothing into the datapath.
// Define L2_TAG_MON_SVA_EN to embed assertions on rising sticky flags plus coverage points.
module l2_tag_req_latency_monitor
  import l2_tag_mon_pkg::*;
#(
  parameter int unsigned           NUM_REQ_CH     = NUM_REQ_CH_DEF,
  parameter logic [NUM_REQ_CH-1:0] MANDATORY_MASK = MANDATORY_MASK_DEF,
  parameter int unsigned           MAX_LAT        = MAX_LAT_DEF,
  parameter int unsigned           OUTSTANDING    = OUTSTANDING_DEF,
  parameter int unsigned           LAT_W          = LAT_W_DEF,
  parameter int unsigned           CNT_W          = CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ_CH-1:0]              req_valid,
  input  logic [NUM_REQ_CH-1:0]              req_ready,
  input  logic                               rsp_valid,
  input  logic                               rsp_ready,
  input  logic                               flush_active,
  input  logic                               clear,
  output logic                               err_protocol,
  output logic                               err_timeout,
  output logic                               err_overflow,
  output logic                               err_unexpected,
  output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding,
  output logic [LAT_W-1:0]                   lat_last,
  output logic [LAT_W-1:0]                   lat_max,
  output logic [CNT_W-1:0]                   req_cnt
);

  localparam int unsigned OccW = $clog2(OUTSTANDING + 1);

  // Entry ages are sized by the shared package type.
  if (LAT_W != LAT_W_DEF) begin : g_lat_w_check
    $error("LAT_W must equal l2_tag_mon_pkg::LAT_W_DEF");
  end

  logic [NUM_REQ_CH-1:0] hs, seen_q, seen_d, pend_q, pend_d;
  logic                  group_done, push, rsp_hs, pop_ok, timeout_ev;
  logic                  fifo_full, fifo_empty;
  age_entry_t            head, next_head, cand;
  logic [NUM_ERR-1:0]    err_ev, err_q, err_d;
  logic [LAT_W-1:0]      lat_last_q, lat_last_d, lat_max_q, lat_max_d, lat_max_base;
  logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;

  always_comb begin
    hs         = req_valid & req_ready;
    pend_d     = req_valid & ~req_ready;
    group_done = &(seen_q | hs | ~MANDATORY_MASK);
    seen_d     = group_done ? '0 : (seen_q | hs);
    push       = group_done & ~flush_active;
    rsp_hs     = rsp_valid & rsp_ready & ~flush_active;
    pop_ok     = rsp_hs & ~fifo_empty;
    // Timeout is judged on whichever entry is oldest after this edge.
    cand       = pop_ok ? next_head : head;
    timeout_ev = cand.valid & ~cand.flagged & (32'(age_inc(cand.age)) > MAX_LAT);

    err_ev                 = '0;
    err_ev[ERR_PROTOCOL]   = (|(pend_q & ~req_valid)) | (|(hs & seen_q));
    err_ev[ERR_TIMEOUT]    = timeout_ev;
    err_ev[ERR_OVERFLOW]   = push & fifo_full & ~pop_ok;
    err_ev[ERR_UNEXPECTED] = rsp_hs & fifo_empty;
    err_d                  = (clear ? '0 : err_q) | err_ev;

    lat_max_base = clear ? '0 : lat_max_q;
    lat_last_d   = clear ? '0 : lat_last_q;
    lat_max_d    = lat_max_base;
    if (pop_ok) begin
      lat_last_d = head.age;
      if (head.age > lat_max_base) lat_max_d = head.age;
    end
    req_cnt_d = (clear ? '0 : req_cnt_q) + CNT_W'(group_done);
  end

  l2_tag_mon_age_fifo #(
    .DEPTH (OUTSTANDING),
    .OCC_W (OccW)
  ) u_age_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (rsp_hs),
    .mark_i  (timeout_ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding),
    .head_o  (head),
    .next_o  (next_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q     <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      lat_last_q <= '0;
      lat_max_q  <= '0;
      req_cnt_q  <= '0;
    end else begin
      seen_q     <= seen_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      lat_last_q <= lat_last_d;
      lat_max_q  <= lat_max_d;
      req_cnt_q  <= req_cnt_d;
    end
  end

  assign err_protocol   = err_q[ERR_PROTOCOL];
  assign err_timeout    = err_q[ERR_TIMEOUT];
  assign err_overflow   = err_q[ERR_OVERFLOW];
  assign err_unexpected = err_q[ERR_UNEXPECTED];
  assign lat_last       = lat_last_q;
  assign lat_max        = lat_max_q;
  assign req_cnt        = req_cnt_q;

`ifdef L2_TAG_MON_SVA_EN
  for (genvar i = 0; i < NUM_ERR; i++) begin : g_err_sva
    a_err_rise : assert property (@(posedge clk) disable iff (rst) !$rose(err_q[i]))
      else $error("l2_tag_req_latency_monitor: sticky error %0d raised", i);
  end
  c_full : cover property (@(posedge clk) disable iff (rst) outstanding == OccW'(OUTSTANDING));
  c_lat_max : cover property (@(posedge clk) disable iff (rst) lat_max_q == LAT_W'(MAX_LAT));
`endif

endmodule
